// File: rtl/store_chk_pkg.sv
// Shared types and defaults for the store_chk storage-element checker.
// Also provides the bench clock-period macro T.
`ifndef T
`define T 10
`endif

package store_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam int WIN_DEF   = 16;
    localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/store_chk_if.sv
// Observation/status bundle between a stimulus source and store_chk.
interface store_chk_if
    import store_chk_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) ();

    logic             start;
    logic             en_obs;
    logic             in_obs;
    logic             d_r_obs;
    logic             l_obs;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] first_err;

    modport master (
        output start, en_obs, in_obs, d_r_obs, l_obs,
        input  busy, done, pass, err_cnt, first_err
    );

    modport slave (
        input  start, en_obs, in_obs, d_r_obs, l_obs,
        output busy, done, pass, err_cnt, first_err
    );

endinterface

// File: rtl/store_chk_model.sv
// Expected-value model for the flop (1-cycle delay) and, with STORE_CHK_LATCH_EN
// defined, the transparent-high latch; flags a mismatch against the observed outputs.
module store_chk_model (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic active,
    input  logic en_obs,
    input  logic in_obs,
    input  logic d_r_obs,
    input  logic l_obs,
    output logic mismatch
);

    logic exp_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_d <= 1'b0;
        end else if (active) begin
            exp_d <= in_obs;
        end
    end

`ifdef STORE_CHK_LATCH_EN
    logic lat_q;
    logic lat_valid;
    logic exp_l;
    logic l_valid;

    // Captured value stands in for the latch's held state once enable drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_q     <= 1'b0;
            lat_valid <= 1'b0;
        end else if (clear) begin
            lat_valid <= 1'b0;
        end else if (active && en_obs) begin
            lat_q     <= in_obs;
            lat_valid <= 1'b1;
        end
    end

    assign exp_l    = en_obs ? in_obs : lat_q;
    assign l_valid  = en_obs || lat_valid;
    assign mismatch = (d_r_obs != exp_d) || (l_valid && (l_obs != exp_l));
`else
    logic unused_latch;

    assign unused_latch = ^{en_obs, l_obs, clear};
    assign mismatch     = (d_r_obs != exp_d);
`endif

endmodule

// File: rtl/store_chk.sv
// Run controller for the storage-element checker: FSM, cycle index and saturating
// error counters. Latch checking inside store_chk_model follows STORE_CHK_LATCH_EN.
module store_chk
    import store_chk_pkg::*;
#(
    parameter int WIN   = WIN_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    store_chk_if.slave   bus
);

    localparam logic [CNT_W-1:0] ALL_ONES = '1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIN - 1);

    state_t           state;
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] err_q;
    logic [CNT_W-1:0] first_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;

    logic             accept;
    logic             active;
    logic             mismatch;

    assign accept = bus.start && ((state == ST_IDLE) || (state == ST_DONE));
    assign active = (state == ST_ARM) || (state == ST_CHECK);

    store_chk_model u_model (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept),
        .active   (active),
        .en_obs   (bus.en_obs),
        .in_obs   (bus.in_obs),
        .d_r_obs  (bus.d_r_obs),
        .l_obs    (bus.l_obs),
        .mismatch (mismatch)
    );

    // pass is decided on the last CHECK cycle, so it folds in that cycle's mismatch too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            idx     <= '0;
            err_q   <= '0;
            first_q <= ALL_ONES;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state   <= ST_ARM;
                        idx     <= '0;
                        err_q   <= '0;
                        first_q <= ALL_ONES;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end
                end
                ST_ARM: begin
                    state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        if (err_q != ALL_ONES) begin
                            err_q <= err_q + 1'b1;
                        end
                        if (err_q == '0) begin
                            first_q <= idx;
                        end
                    end
                    if (idx == LAST_IDX) begin
                        state  <= ST_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        pass_q <= (err_q == '0) && !mismatch;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_cnt   = err_q;
    assign bus.first_err = first_q;

endmodule

// File: doc/store_chk.md
STORE_CHK -- requirements
Module: store_chk

Interface
REQ-001 Parameter WIN, default 16, number of compared cycles per run (2..255).
REQ-002 Parameter CNT_W, default 8, width of error counter and cycle index.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle pulse; begins a run from IDLE or DONE.
REQ-006 en_obs  input  1  observed enable driven into the storage element under check.
REQ-007 in_obs  input  1  observed data driven into the storage element under check.
REQ-008 d_r_obs  input  1  observed rising-edge flop output.
REQ-009 l_obs  input  1  observed latch output.
REQ-010 busy  output  1  high in ARM and CHECK.
REQ-011 done  output  1  high in DONE.
REQ-012 pass  output  1  valid while done; high when err_cnt is 0.
REQ-013 err_cnt  output  CNT_W  mismatch count of the current/last run, saturating.
REQ-014 first_err  output  CNT_W  CHECK-cycle index (0-based) of the first mismatch; all-ones if none.

Function
REQ-015 FSM states SHALL be IDLE, ARM, CHECK, DONE.
REQ-016 IDLE->ARM on start; ARM->CHECK after exactly one cycle; CHECK->DONE after WIN cycles; DONE->ARM on start.
REQ-017 start SHALL be ignored in ARM and CHECK.
REQ-018 On entry to ARM: err_cnt cleared, first_err set all-ones, cycle index cleared, latch-model valid bit cleared.
REQ-019 In ARM and CHECK, exp_d SHALL register in_obs each cycle (flop model, 1-cycle latency).
REQ-020 In CHECK, d_r_obs != exp_d SHALL count as one mismatch.
REQ-021 Latch model: when en_obs=1, exp_l = in_obs (same cycle) and valid set; when en_obs=0, exp_l holds the last value captured.
REQ-022 Latch mismatch SHALL be counted only when model valid; d_r and latch mismatches in one cycle count as one.
REQ-023 err_cnt SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-024 first_err SHALL load the cycle index on the first mismatch of a run only.
REQ-025 pass SHALL be low outside DONE.
REQ-026 Outputs SHALL hold their last values in DONE until the next start.

Reset
REQ-027 Asserting rst SHALL force IDLE, busy=0, done=0, pass=0, err_cnt=0, first_err all-ones, exp_d=0, latch valid=0.
REQ-028 rst asserted mid-CHECK SHALL abort the run with no DONE pulse; a start is required afterwards.

Configuration
REQ-029 Macro STORE_CHK_LATCH_EN: when defined, latch checking per REQ-021/022 is compiled in.
REQ-030 Without STORE_CHK_LATCH_EN, l_obs and en_obs are unused, and only d_r_obs is compared.

Structure
REQ-031 The shared package SHALL hold the FSM state enum, default WIN and CNT_W constants, and the bench clock-period macro T.
REQ-032 The flop/latch expected-value model SHALL be a sub-module store_chk_model; the FSM and counters stay in store_chk.

Verification
REQ-033 Ideal DUT, in_obs toggling every cycle, en_obs=1, start -> done after 1+16 cycles, pass=1, err_cnt=0, first_err=8'hFF.
REQ-034 d_r_obs forced inverted on CHECK cycle 5 only -> err_cnt=1, first_err=5, pass=0.
REQ-035 d_r_obs constantly inverted with WIN=255, CNT_W=8 -> err_cnt=255 (saturated), first_err=0.
REQ-036 With latch enabled: en_obs=0 before any en_obs=1, l_obs random -> no latch errors; after en_obs=1 with in_obs=1, then en_obs=0 and l_obs=0 -> err_cnt increments each such cycle.
REQ-037 rst pulsed at CHECK cycle 7 -> all outputs at reset values immediately; start ignored mid-run; next start runs cleanly.
REQ-038 start asserted during CHECK -> no restart; run completes on schedule.
